// File: rtl/wb_pattern_master.sv
// Wishbone classic-cycle pattern test master.
// Writes DATA_COUNT generated words to a slave region and reads them back for checking.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start, seed     run request (falling edge starts a run), pattern seed
//   busy, done      run in progress, run finished (sticky until next run)
//   err, timed_out  read mismatch seen, run aborted on missing ack (sticky)
//   err_count       saturating mismatch count for the current run
//   cyc_o .. adr_o  Wishbone master bus
module wb_pattern_master #(
  parameter int BASE_ADDRESS = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_COUNT   = 16,
  parameter int AU_IN_DATA   = 1,
  parameter int PATTERN_STEP = 1,
  parameter int MODE         = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  timed_out,
  output logic [15:0]           err_count,
  output logic                  cyc_o,
  output logic                  stb_o,
  input  logic                  ack_i,
  output logic                  we_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [ADDR_WIDTH-1:0] adr_o
);

  localparam int IW = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IW-1:0] LAST = IW'(DATA_COUNT - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  localparam logic [DATA_WIDTH-1:0] STEP   = DATA_WIDTH'(PATTERN_STEP);
  localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDRESS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(AU_IN_DATA);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4
  } state_t;

  state_t                  state;
  logic                    start_old;
  logic [IW-1:0]           idx;
  logic [DATA_WIDTH-1:0]   seed_q;
  // word/addr track word(idx)/adr(idx) incrementally, no multiplier
  logic [DATA_WIDTH-1:0]   word;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [TW-1:0]           wcnt;
  logic                    tmo;

  // wcnt == TIMEOUT-1 means this is the TIMEOUT-th cycle without ack
  assign tmo = (TIMEOUT != 0) && (wcnt == TLIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      start_old <= 1'b0;
      idx       <= '0;
      seed_q    <= '0;
      word      <= '0;
      addr      <= '0;
      wcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      timed_out <= 1'b0;
      err_count <= '0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      dat_o     <= '0;
      adr_o     <= '0;
    end else begin
      start_old <= start;
      case (state)
        IDLE: begin
          if (!start && start_old) begin
            done      <= 1'b0;
            err       <= 1'b0;
            timed_out <= 1'b0;
            err_count <= '0;
            busy      <= 1'b1;
            seed_q    <= seed;
            word      <= seed;
            addr      <= BASE;
            idx       <= '0;
            state     <= WR_REQ;
          end
        end
        WR_REQ: begin
          cyc_o <= 1'b1;
          stb_o <= 1'b1;
          we_o  <= 1'b1;
          dat_o <= word;
          adr_o <= addr;
          wcnt  <= '0;
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (ack_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            if (MODE == 0) begin
              state <= RD_REQ;
            end else if (idx != LAST) begin
              idx   <= idx + IW'(1);
              word  <= word + STEP;
              addr  <= addr + STRIDE;
              state <= WR_REQ;
            end else begin
              // write phase over: rewind to word 0 for the read phase
              idx   <= '0;
              word  <= seed_q;
              addr  <= BASE;
              state <= RD_REQ;
            end
          end else if (tmo) begin
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            timed_out <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        RD_REQ: begin
          cyc_o <= 1'b1;
          stb_o <= 1'b1;
          we_o  <= 1'b0;
          adr_o <= addr;
          wcnt  <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (ack_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            if (dat_i != word) begin
              err <= 1'b1;
              if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
              end
            end
            if (idx == LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= idx + IW'(1);
              word  <= word + STEP;
              addr  <= addr + STRIDE;
              state <= (MODE == 0) ? WR_REQ : RD_REQ;
            end
          end else if (tmo) begin
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            timed_out <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        default: begin
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
          we_o  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_pattern_master.sv
// Bench for wb_pattern_master: two instances (interleaved and write-all-then-read)
// with RAM slave models, bus/status scoreboards and directed runs.
module tb_wb_pattern_master;

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
  } bus_t;

  typedef struct packed {
    logic        to;
    logic        er;
    logic [15:0] cnt;
    logic [7:0]  hang;
  } st_t;

  logic        clk;
  logic        rst;
  logic        start     [2];
  logic [31:0] seed      [2];
  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];
  logic        timed_out [2];
  logic [15:0] err_count [2];
  logic        cyc       [2];
  logic        stb       [2];
  logic        ack       [2];
  logic        we        [2];
  logic [31:0] dat_o     [2];
  logic [31:0] dat_i     [2];
  logic [15:0] adr       [2];

  int total = 0;
  int bad   = 0;

  bus_t q0[$];
  bus_t q1[$];
  st_t  s0[$];
  st_t  s1[$];

  int          delay    [2];
  int          wcnt_s   [2];
  int          hang_wr  [2];
  int          wr_n     [2];
  int          hang_cyc [2];
  logic [15:0] corrupt  [2];
  logic [31:0] mem      [2][1024];
  logic        done_q   [2];
  logic [3:0]  sidx;

  wb_pattern_master #(
    .MODE(0), .TIMEOUT(8)
  ) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .seed(seed[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]),
    .timed_out(timed_out[0]), .err_count(err_count[0]),
    .cyc_o(cyc[0]), .stb_o(stb[0]), .ack_i(ack[0]), .we_o(we[0]),
    .dat_o(dat_o[0]), .dat_i(dat_i[0]), .adr_o(adr[0])
  );

  wb_pattern_master #(
    .MODE(1), .TIMEOUT(8), .AU_IN_DATA(4), .BASE_ADDRESS('h100)
  ) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .seed(seed[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]),
    .timed_out(timed_out[1]), .err_count(err_count[1]),
    .cyc_o(cyc[1]), .stb_o(stb[1]), .ack_i(ack[1]), .we_o(we[1]),
    .dat_o(dat_o[1]), .dat_i(dat_i[1]), .adr_o(adr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic observe(int k, logic w, logic [15:0] a, logic [31:0] d);
    bus_t got;
    bus_t e;
    got.we  = w;
    got.adr = a;
    got.dat = w ? d : 32'h0;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL bus_extra%0d: got %h want none", k, got);
    end else begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("bus%0d", k), 64'(got), 64'(e));
    end
  endtask

  // Slave RAM + bus monitor: acks after delay[k] wait cycles.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ack[k]) begin
        ack[k] = 1'b0;
      end else if (cyc[k] && stb[k]) begin
        if (we[k] && wr_n[k] == hang_wr[k]) begin
          hang_cyc[k]++;
        end else if (wcnt_s[k] != delay[k]) begin
          wcnt_s[k]++;
        end else begin
          wcnt_s[k] = 0;
          ack[k] = 1'b1;
          sidx = (k == 0) ? adr[k][3:0] : adr[k][5:2];
          if (we[k]) begin
            mem[k][adr[k][9:0]] = dat_o[k];
            wr_n[k]++;
          end else begin
            dat_i[k] = mem[k][adr[k][9:0]] ^ {31'h0, corrupt[k][sidx]};
          end
          observe(k, we[k], adr[k], dat_o[k]);
        end
      end
    end
  end

  // Status monitor: compare end-of-run status on each rising done.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (done[k] && !done_q[k]) begin
        st_t g;
        st_t e;
        g.to   = timed_out[k];
        g.er   = err[k];
        g.cnt  = err_count[k];
        g.hang = 8'(hang_cyc[k]);
        if ((k == 0 && s0.size() == 0) || (k == 1 && s1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL st_extra%0d: got %h want none", k, g);
        end else begin
          e = (k == 0) ? s0.pop_front() : s1.pop_front();
          check($sformatf("status%0d", k), {busy[k], g}, {1'b0, e});
        end
      end
      done_q[k] = done[k];
    end
  end

  task automatic push_bus(int k, logic w, logic [15:0] a, logic [31:0] d);
    bus_t t;
    t.we  = w;
    t.adr = a;
    t.dat = w ? d : 32'h0;
    if (k == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  task automatic push_run(int k, logic [31:0] s, int hang);
    if (k == 0) begin
      for (int i = 0; i < 16; i++) begin
        if (hang >= 0 && i >= hang) break;
        push_bus(0, 1'b1, 16'(i), s + 32'(i));
        push_bus(0, 1'b0, 16'(i), 32'h0);
      end
    end else begin
      for (int i = 0; i < 16; i++)
        push_bus(1, 1'b1, 16'h100 + 16'(4 * i), s + 32'(i));
      for (int i = 0; i < 16; i++)
        push_bus(1, 1'b0, 16'h100 + 16'(4 * i), 32'h0);
    end
  endtask

  task automatic push_st(int k, logic to, logic er, logic [15:0] c, int h);
    st_t t;
    t.to   = to;
    t.er   = er;
    t.cnt  = c;
    t.hang = 8'(h);
    if (k == 0) s0.push_back(t);
    else s1.push_back(t);
  endtask

  task automatic start_run(int k, logic [31:0] s);
    @(posedge clk);
    #1;
    wr_n[k]     = 0;
    hang_cyc[k] = 0;
    seed[k]     = s;
    start[k]    = 1'b1;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
  endtask

  task automatic wait_done(int k, int budget);
    int n = 0;
    repeat (2) @(posedge clk);
    #1;
    while (!done[k] && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("done%0d", k), 64'(done[k]), 64'd1);
    @(negedge clk);
    #1;
    check($sformatf("busq%0d", k),
          64'((k == 0) ? q0.size() : q1.size()), 64'd0);
    check($sformatf("stq%0d", k),
          64'((k == 0) ? s0.size() : s1.size()), 64'd0);
  endtask

  task automatic check_idle0(string nm, int k);
    check({nm, "_ctl"},
          64'({cyc[k], stb[k], we[k], busy[k], done[k], err[k],
               timed_out[k], err_count[k]}), 64'd0);
    check({nm, "_bus"}, 64'({dat_o[k], adr[k]}), 64'd0);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k]    = 1'b0;
      seed[k]     = 32'h0;
      ack[k]      = 1'b0;
      dat_i[k]    = 32'h0;
      delay[k]    = 0;
      wcnt_s[k]   = 0;
      hang_wr[k]  = -1;
      wr_n[k]     = 0;
      hang_cyc[k] = 0;
      corrupt[k]  = 16'h0;
      done_q[k]   = 1'b0;
    end
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle0("rst0", 0);
    check_idle0("rst1", 1);
    rst = 1'b1;

    // T1: interleaved, 1-cycle ack
    push_run(0, 32'h1000, -1);
    push_st(0, 1'b0, 1'b0, 16'd0, 0);
    start_run(0, 32'h1000);
    wait_done(0, 200);

    // T2: write-all-then-read, stride 4 from 0x100
    push_run(1, 32'h2000, -1);
    push_st(1, 1'b0, 1'b0, 16'd0, 0);
    start_run(1, 32'h2000);
    wait_done(1, 200);

    // T3: corrupt reads of words 3 and 7
    corrupt[0] = 16'h0088;
    push_run(0, 32'h3000, -1);
    push_st(0, 1'b0, 1'b1, 16'd2, 0);
    start_run(0, 32'h3000);
    wait_done(0, 200);
    corrupt[0] = 16'h0;
    check("t3_err", 64'({err[0], err_count[0]}), 64'({1'b1, 16'd2}));

    // T5: slow slave, new start clears sticky status, mid-run start ignored
    delay[0] = 3;
    push_run(0, 32'h5000, -1);
    push_st(0, 1'b0, 1'b0, 16'd0, 0);
    start_run(0, 32'h5000);
    @(posedge clk);
    #1;
    check("t5_clr", 64'({busy[0], done[0], err[0], err_count[0]}),
          64'({1'b1, 1'b0, 1'b0, 16'd0}));
    repeat (20) @(posedge clk);
    #1;
    start[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_busy", 64'(busy[0]), 64'd1);
    wait_done(0, 400);
    repeat (10) @(posedge clk);
    #1;
    check("t5_noextra", 64'({busy[0], done[0]}), 64'({1'b0, 1'b1}));
    delay[0] = 0;
    push_run(0, 32'h5A5A0000, -1);
    push_st(0, 1'b0, 1'b0, 16'd0, 0);
    start_run(0, 32'h5A5A0000);
    @(posedge clk);
    #1;
    check("t5_rerun", 64'({busy[0], done[0]}), 64'({1'b1, 1'b0}));
    wait_done(0, 200);

    // T4: 5th write never acked, abort after 8 wait cycles
    hang_wr[0] = 4;
    push_run(0, 32'h4000, 4);
    push_st(0, 1'b1, 1'b0, 16'd0, 8);
    start_run(0, 32'h4000);
    wait_done(0, 200);
    hang_wr[0] = -1;
    check("t4_flags", 64'({timed_out[0], busy[0], err[0], cyc[0]}),
          64'({1'b1, 1'b0, 1'b0, 1'b0}));

    // T6: reset in RD_WAIT of word 6, then clean rerun
    delay[0] = 2;
    push_run(0, 32'h6000, -1);
    start_run(0, 32'h6000);
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (cyc[0] && !we[0] && adr[0] == 16'd6) found = 1'b1;
    end
    check("t6_reach", 64'(found), 64'd1);
    #2 rst = 1'b0;
    #1;
    check_idle0("t6_rst", 0);
    q0.delete();
    ack[0]    = 1'b0;
    wcnt_s[0] = 0;
    delay[0]  = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    push_run(0, 32'h6100, -1);
    push_st(0, 1'b0, 1'b0, 16'd0, 0);
    start_run(0, 32'h6100);
    wait_done(0, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
